cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Producer end of the common data bus consumed by the RS, ROB and map table. Buffers one
//  completed result per functional unit, picks up to N per cycle with rotating priority, and
//  drives the N-wide CDB. Back-pressures FUs that lose arbitration. Squashes or clears
//  branch-mask bits on buffered results.
// PARAMETERS
//  N        `N           CDB width, broadcasts per cycle
//  NUM_FU   `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LD+`NUM_FU_BR   result-producing FUs, stores excluded
//  PTR_W    $clog2(NUM_FU)   rotating-priority pointer width
// PORTS
//  clock         in   1                  system clock
//  reset         in   1                  synchronous, active-high
//  fu_valid      in   NUM_FU             FU i presents a completed result this cycle
//  fu_tag        in   NUM_FU x PRN_W     destination physical register (PRN_W=$clog2(`PHYS_REG_SZ))
//  fu_data       in   NUM_FU x 32        result value
//  fu_bmask      in   NUM_FU x BR_MASK   branch mask of the producing instruction
//  br_id         in   BR_MASK            one-hot branch being resolved
//  br_task       in   BR_TASK            NOTHING / CLEAR / SQUASH
//  fu_ready      out  NUM_FU             FU i may present a new result this cycle
//  cdb_out       out  N x CDB_PACKET     {valid, reg_idx, value}; slot 0 = highest priority
//  hold_count    out  $clog2(NUM_FU+1)   occupied holding registers, for debug and perf counters
// BEHAVIOUR
//  - Storage: one holding register per FU {valid, tag, data, bmask}, plus the pointer rr_ptr.
//  - Reset: in the cycle after reset, all holds are invalid, rr_ptr=0, cdb_out all zero,
//    hold_count=0 and fu_ready all-ones. Inputs are ignored while reset is high.
//  - Request: req[i] = hold[i].valid && !(br_task==SQUASH && (hold[i].bmask & br_id)!=0).
//  - Grant: scan from rr_ptr upward, modulo NUM_FU. The first N requesters are granted.
//    The k-th grant drives cdb_out[k] combinationally from the holding register.
//    Unused slots have valid=0 and all fields zero.
//  - Pointer: if any grant occurs, rr_ptr <= (index of last grant + 1) mod NUM_FU.
//    Otherwise rr_ptr is unchanged.
//  - Ready: fu_ready[i] = !hold[i].valid || grant[i] || squashed[i].
//    This is combinational, so a granted hold is refilled in the same cycle.
//  - Accept: when fu_valid[i] && fu_ready[i], hold[i] loads the FU result at the next edge.
//    If fu_valid[i] && !fu_ready[i], the FU must hold its outputs stable. Loss is a protocol error.
//  - Latency: a result accepted at edge t appears on the CDB no earlier than the cycle after
//    edge t. Minimum FU-to-CDB latency is 1 cycle. Worst-case wait is ceil(NUM_FU/N)-1 extra
//    cycles.
//  - SQUASH:
//    - Holds with (bmask & br_id)!=0 are cleared at the edge and are not broadcast that cycle.
//    - An incoming fu result whose bmask matches br_id is dropped, not loaded.
//  - CLEAR:
//    - Each hold and each loaded incoming result stores bmask & ~br_id.
//    - Broadcast in the same cycle still shows the data; bmask is not part of CDB_PACKET.
//  - Simultaneous grant and SQUASH on the same hold: the squash wins, with no broadcast.
//  - Simultaneous grant and refill: the old value is broadcast and the new value is loaded.
//  - Full: all NUM_FU holds valid. fu_ready is 1 only for granted or squashed FUs.
//    There is no deadlock as long as N>=1.
//  - Empty: cdb_out all invalid and rr_ptr holds.
//  - NUM_FU<=N: every valid hold is granted each cycle, so fu_ready stays all-ones.
//  - hold_count is the registered popcount of hold valid bits.
// TESTING
//  1 Reset, then FU0 valid with tag=5 and data=0xDEAD -> next cycle cdb_out[0]={1,5,0xDEAD};
//    all fu_ready=1.
//  2 N=2, NUM_FU=5, all FUs valid in one cycle -> broadcasts FU{0,1}, then {2,3}, then {4,0'};
//    rr_ptr reads 2,4,1; fu_ready[2..4]=0 during the first cycle.
//  3 Hold FU3 with bmask=0b0100, then SQUASH with br_id=0b0100 while it is granted ->
//    no broadcast; hold cleared; the next requester takes slot 0 the same cycle.
//  4 Hold bmask=0b0110, then CLEAR with br_id=0b0010 -> stored bmask=0b0100.
//    A later SQUASH with br_id=0b0010 does not kill it.
//  5 FU1 granted while it presents a new result -> old result on the CDB this cycle,
//    new result next cycle, and fu_ready[1]=1 throughout.
//  6 Assert reset with 4 holds valid -> next cycle everything is empty, cdb_out=0,
//    and hold_count=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the common data bus.
// Each result-producing FU owns one holding register. Up to N holds are picked
// per cycle with rotating priority and driven onto the N-wide CDB; slot 0 is
// the highest-priority grant. Branch resolution can squash buffered results or
// clear their branch-mask bits.
module cdb_arbiter #(
  parameter int N       = 2,
  parameter int NUM_FU  = 5,
  parameter int PRN_W   = 6,
  parameter int BR_MASK = 4,
  parameter int BR_TASK = 2,
  parameter int PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int CNT_W   = $clog2(NUM_FU + 1),
  parameter int PKT_W   = 1 + PRN_W + 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_FU-1:0]                 fu_valid,
  input  logic [NUM_FU-1:0][PRN_W-1:0]      fu_tag,
  input  logic [NUM_FU-1:0][31:0]           fu_data,
  input  logic [NUM_FU-1:0][BR_MASK-1:0]    fu_bmask,
  input  logic [BR_MASK-1:0]                br_id,
  input  logic [BR_TASK-1:0]                br_task,
  output logic [NUM_FU-1:0]                 fu_ready,
  output logic [N-1:0][PKT_W-1:0]           cdb_out,
  output logic [CNT_W-1:0]                  hold_count
);

  // Branch-resolution commands carried on br_task.
  typedef enum logic [BR_TASK-1:0] {
    BR_NOTHING = BR_TASK'(0),
    BR_CLEAR   = BR_TASK'(1),
    BR_SQUASH  = BR_TASK'(2)
  } br_task_e;

  logic [NUM_FU-1:0]              hold_valid;
  logic [NUM_FU-1:0][PRN_W-1:0]   hold_tag;
  logic [NUM_FU-1:0][31:0]        hold_data;
  logic [NUM_FU-1:0][BR_MASK-1:0] hold_bmask;
  logic [PTR_W-1:0]               rr_ptr;

  logic [NUM_FU-1:0]              hold_valid_nxt;
  logic [NUM_FU-1:0][PRN_W-1:0]   hold_tag_nxt;
  logic [NUM_FU-1:0][31:0]        hold_data_nxt;
  logic [NUM_FU-1:0][BR_MASK-1:0] hold_bmask_nxt;
  logic [PTR_W-1:0]               rr_ptr_nxt;
  logic [CNT_W-1:0]               hold_count_nxt;

  logic [NUM_FU-1:0]              squashed;
  logic [NUM_FU-1:0]              req;
  logic [NUM_FU-1:0]              grant;
  logic [PTR_W-1:0]               last_idx;
  logic                           any_grant;
  logic                           squash_on;
  logic                           clear_on;

  assign squash_on = (br_task_e'(br_task) == BR_SQUASH);
  assign clear_on  = (br_task_e'(br_task) == BR_CLEAR);

  // A hold hit by the branch being squashed is killed this cycle and must not request.
  always_comb begin
    squashed = '0;
    req      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      squashed[i] = hold_valid[i] && squash_on && ((hold_bmask[i] & br_id) != '0);
      req[i]      = hold_valid[i] && !squashed[i];
    end
  end

  // Scan requesters from rr_ptr upward (wrapping) and hand the first N to CDB slots in order.
  always_comb begin
    logic [PTR_W:0] sum;
    logic [PTR_W-1:0] pos;
    int rank;
    grant     = '0;
    cdb_out   = '0;
    any_grant = 1'b0;
    last_idx  = rr_ptr;
    rank      = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(j);
      if (sum >= (PTR_W + 1)'(NUM_FU)) begin
        sum = sum - (PTR_W + 1)'(NUM_FU);
      end
      pos = sum[PTR_W-1:0];
      if (req[pos] && (rank < N)) begin
        grant[pos] = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (rank == k) begin
            cdb_out[k] = {1'b1, hold_tag[pos], hold_data[pos]};
          end
        end
        rank      = rank + 1;
        last_idx  = pos;
        any_grant = 1'b1;
      end
    end
  end

  // A hold can take a new result when it is empty, leaving on the CDB, or being squashed.
  assign fu_ready = ~hold_valid | grant | squashed;

  // Next hold contents: refill freed holds, drop squashed incoming results, apply CLEAR to survivors.
  always_comb begin
    hold_valid_nxt = hold_valid;
    hold_tag_nxt   = hold_tag;
    hold_data_nxt  = hold_data;
    hold_bmask_nxt = hold_bmask;
    hold_count_nxt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_ready[i]) begin
        if (fu_valid[i] && !(squash_on && ((fu_bmask[i] & br_id) != '0))) begin
          hold_valid_nxt[i] = 1'b1;
          hold_tag_nxt[i]   = fu_tag[i];
          hold_data_nxt[i]  = fu_data[i];
          hold_bmask_nxt[i] = clear_on ? (fu_bmask[i] & ~br_id) : fu_bmask[i];
        end else begin
          hold_valid_nxt[i] = 1'b0;
        end
      end else if (clear_on) begin
        hold_bmask_nxt[i] = hold_bmask[i] & ~br_id;
      end
      hold_count_nxt = hold_count_nxt + CNT_W'(hold_valid_nxt[i]);
    end
  end

  // Priority moves just past the last granted FU; with no grant it stays put.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (any_grant) begin
      if (last_idx == PTR_W'(NUM_FU - 1)) begin
        rr_ptr_nxt = '0;
      end else begin
        rr_ptr_nxt = last_idx + PTR_W'(1);
      end
    end
  end

  // Register holds, pointer and occupancy; reset empties everything and ignores inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= '0;
      hold_tag   <= '0;
      hold_data  <= '0;
      hold_bmask <= '0;
      rr_ptr     <= '0;
      hold_count <= '0;
    end else begin
      hold_valid <= hold_valid_nxt;
      hold_tag   <= hold_tag_nxt;
      hold_data  <= hold_data_nxt;
      hold_bmask <= hold_bmask_nxt;
      rr_ptr     <= rr_ptr_nxt;
      hold_count <= hold_count_nxt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios for the CDB arbiter (N=2, NUM_FU=5).
module tb_cdb_arbiter;

  localparam int N       = 2;
  localparam int NUM_FU  = 5;
  localparam int PRN_W   = 6;
  localparam int BR_MASK = 4;
  localparam int PKT_W   = 1 + PRN_W + 32;

  logic                           clock;
  logic                           reset;
  logic [NUM_FU-1:0]              fu_valid;
  logic [NUM_FU-1:0][PRN_W-1:0]   fu_tag;
  logic [NUM_FU-1:0][31:0]        fu_data;
  logic [NUM_FU-1:0][BR_MASK-1:0] fu_bmask;
  logic [BR_MASK-1:0]             br_id;
  logic [1:0]                     br_task;
  logic [NUM_FU-1:0]              fu_ready;
  logic [N-1:0][PKT_W-1:0]        cdb_out;
  logic [2:0]                     hold_count;

  int checks;
  int failures;

  cdb_arbiter #(.N(N), .NUM_FU(NUM_FU), .PRN_W(PRN_W), .BR_MASK(BR_MASK)) dut (
    .clock(clock),
    .reset(reset),
    .fu_valid(fu_valid),
    .fu_tag(fu_tag),
    .fu_data(fu_data),
    .fu_bmask(fu_bmask),
    .br_id(br_id),
    .br_task(br_task),
    .fu_ready(fu_ready),
    .cdb_out(cdb_out),
    .hold_count(hold_count)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [PKT_W-1:0] pkt(input logic [PRN_W-1:0] t, input logic [31:0] d);
    return {1'b1, t, d};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
    fu_bmask = '0;
    br_id    = '0;
    br_task  = 2'd0;
  endtask

  task automatic set_fu(input int i, input logic [PRN_W-1:0] t, input logic [31:0] d,
                        input logic [BR_MASK-1:0] m);
    fu_valid[i] = 1'b1;
    fu_tag[i]   = t;
    fu_data[i]  = d;
    fu_bmask[i] = m;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #2;
    checks++; if (cdb_out !== '0) begin failures++; $display("[TB] FAIL reset_cdb got=%h exp=0", cdb_out); end
    checks++; if (hold_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", hold_count); end
    checks++; if (fu_ready !== 5'b11111) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=11111", fu_ready); end
    checks++; if (dut.rr_ptr !== 3'd0) begin failures++; $display("[TB] FAIL reset_ptr got=%0d exp=0", dut.rr_ptr); end
  endtask

  task automatic test_single();
    apply_reset();
    set_fu(0, 6'd5, 32'hDEAD, 4'b0000);
    #2;
    checks++; if (fu_ready !== 5'b11111) begin failures++; $display("[TB] FAIL single_ready0 got=%b exp=11111", fu_ready); end
    tick();
    clear_inputs();
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd5, 32'hDEAD)) begin failures++; $display("[TB] FAIL single_slot0 got=%h exp=%h", cdb_out[0], pkt(6'd5, 32'hDEAD)); end
    checks++; if (cdb_out[1] !== '0) begin failures++; $display("[TB] FAIL single_slot1 got=%h exp=0", cdb_out[1]); end
    checks++; if (fu_ready !== 5'b11111) begin failures++; $display("[TB] FAIL single_ready1 got=%b exp=11111", fu_ready); end
    checks++; if (hold_count !== 3'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", hold_count); end
    tick();
    #2;
    checks++; if (cdb_out !== '0) begin failures++; $display("[TB] FAIL single_drained got=%h exp=0", cdb_out); end
  endtask

  task automatic test_rotation();
    apply_reset();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(10 + i), 32'h100 + 32'(i), 4'b0000);
    tick();
    clear_inputs();
    set_fu(0, 6'd20, 32'h200, 4'b0000);
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd10, 32'h100)) begin failures++; $display("[TB] FAIL rot_c1_slot0 got=%h exp=%h", cdb_out[0], pkt(6'd10, 32'h100)); end
    checks++; if (cdb_out[1] !== pkt(6'd11, 32'h101)) begin failures++; $display("[TB] FAIL rot_c1_slot1 got=%h exp=%h", cdb_out[1], pkt(6'd11, 32'h101)); end
    checks++; if (fu_ready !== 5'b00011) begin failures++; $display("[TB] FAIL rot_c1_ready got=%b exp=00011", fu_ready); end
    checks++; if (hold_count !== 3'd5) begin failures++; $display("[TB] FAIL rot_c1_count got=%0d exp=5", hold_count); end
    tick();
    clear_inputs();
    #2;
    checks++; if (dut.rr_ptr !== 3'd2) begin failures++; $display("[TB] FAIL rot_ptr2 got=%0d exp=2", dut.rr_ptr); end
    checks++; if (cdb_out[0] !== pkt(6'd12, 32'h102)) begin failures++; $display("[TB] FAIL rot_c2_slot0 got=%h exp=%h", cdb_out[0], pkt(6'd12, 32'h102)); end
    checks++; if (cdb_out[1] !== pkt(6'd13, 32'h103)) begin failures++; $display("[TB] FAIL rot_c2_slot1 got=%h exp=%h", cdb_out[1], pkt(6'd13, 32'h103)); end
    checks++; if (fu_ready !== 5'b01110) begin failures++; $display("[TB] FAIL rot_c2_ready got=%b exp=01110", fu_ready); end
    tick();
    #2;
    checks++; if (dut.rr_ptr !== 3'd4) begin failures++; $display("[TB] FAIL rot_ptr4 got=%0d exp=4", dut.rr_ptr); end
    checks++; if (cdb_out[0] !== pkt(6'd14, 32'h104)) begin failures++; $display("[TB] FAIL rot_c3_slot0 got=%h exp=%h", cdb_out[0], pkt(6'd14, 32'h104)); end
    checks++; if (cdb_out[1] !== pkt(6'd20, 32'h200)) begin failures++; $display("[TB] FAIL rot_c3_slot1 got=%h exp=%h", cdb_out[1], pkt(6'd20, 32'h200)); end
    checks++; if (hold_count !== 3'd2) begin failures++; $display("[TB] FAIL rot_c3_count got=%0d exp=2", hold_count); end
    tick();
    #2;
    checks++; if (dut.rr_ptr !== 3'd1) begin failures++; $display("[TB] FAIL rot_ptr1 got=%0d exp=1", dut.rr_ptr); end
    checks++; if (cdb_out !== '0) begin failures++; $display("[TB] FAIL rot_empty got=%h exp=0", cdb_out); end
    tick();
    #2;
    checks++; if (dut.rr_ptr !== 3'd1) begin failures++; $display("[TB] FAIL rot_ptr_hold got=%0d exp=1", dut.rr_ptr); end
  endtask

  task automatic test_squash_grant();
    apply_reset();
    set_fu(3, 6'd33, 32'h3333, 4'b0100);
    set_fu(4, 6'd44, 32'h4444, 4'b0000);
    tick();
    clear_inputs();
    br_task = 2'd2;
    br_id   = 4'b0100;
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd44, 32'h4444)) begin failures++; $display("[TB] FAIL sq_slot0 got=%h exp=%h", cdb_out[0], pkt(6'd44, 32'h4444)); end
    checks++; if (cdb_out[1] !== '0) begin failures++; $display("[TB] FAIL sq_slot1 got=%h exp=0", cdb_out[1]); end
    checks++; if (fu_ready !== 5'b11111) begin failures++; $display("[TB] FAIL sq_ready got=%b exp=11111", fu_ready); end
    tick();
    clear_inputs();
    #2;
    checks++; if (hold_count !== 3'd0) begin failures++; $display("[TB] FAIL sq_count got=%0d exp=0", hold_count); end
    checks++; if (cdb_out !== '0) begin failures++; $display("[TB] FAIL sq_after got=%h exp=0", cdb_out); end
  endtask

  task automatic test_squash_incoming();
    apply_reset();
    set_fu(1, 6'd9, 32'h9999, 4'b0001);
    br_task = 2'd2;
    br_id   = 4'b0001;
    tick();
    clear_inputs();
    #2;
    checks++; if (hold_count !== 3'd0) begin failures++; $display("[TB] FAIL sqin_count got=%0d exp=0", hold_count); end
    checks++; if (cdb_out !== '0) begin failures++; $display("[TB] FAIL sqin_cdb got=%h exp=0", cdb_out); end
  endtask

  task automatic test_clear();
    apply_reset();
    set_fu(0, 6'd1, 32'hA0, 4'b0000);
    set_fu(1, 6'd2, 32'hA1, 4'b0000);
    set_fu(2, 6'd7, 32'h1234, 4'b0110);
    tick();
    clear_inputs();
    br_task = 2'd1;
    br_id   = 4'b0010;
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd1, 32'hA0)) begin failures++; $display("[TB] FAIL clr_slot0 got=%h exp=%h", cdb_out[0], pkt(6'd1, 32'hA0)); end
    checks++; if (cdb_out[1] !== pkt(6'd2, 32'hA1)) begin failures++; $display("[TB] FAIL clr_slot1 got=%h exp=%h", cdb_out[1], pkt(6'd2, 32'hA1)); end
    tick();
    clear_inputs();
    br_task = 2'd2;
    br_id   = 4'b0010;
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd7, 32'h1234)) begin failures++; $display("[TB] FAIL clr_survive got=%h exp=%h", cdb_out[0], pkt(6'd7, 32'h1234)); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_fu(1, 6'd21, 32'hAAAA, 4'b0000);
    tick();
    clear_inputs();
    set_fu(1, 6'd22, 32'hBBBB, 4'b0000);
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd21, 32'hAAAA)) begin failures++; $display("[TB] FAIL b2b_old got=%h exp=%h", cdb_out[0], pkt(6'd21, 32'hAAAA)); end
    checks++; if (fu_ready[1] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready0 got=%b exp=1", fu_ready[1]); end
    tick();
    clear_inputs();
    #2;
    checks++; if (cdb_out[0] !== pkt(6'd22, 32'hBBBB)) begin failures++; $display("[TB] FAIL b2b_new got=%h exp=%h", cdb_out[0], pkt(6'd22, 32'hBBBB)); end
    checks++; if (fu_ready[1] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready1 got=%b exp=1", fu_ready[1]); end
    tick();
  endtask

  task automatic test_reset_busy();
    apply_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 6'(40 + i), 32'h400 + 32'(i), 4'b0000);
    tick();
    clear_inputs();
    #2;
    checks++; if (hold_count !== 3'd4) begin failures++; $display("[TB] FAIL rstb_count4 got=%0d exp=4", hold_count); end
    reset = 1'b1;
    set_fu(4, 6'd50, 32'h500, 4'b0000);
    tick();
    reset = 1'b0;
    clear_inputs();
    #2;
    checks++; if (cdb_out !== '0) begin failures++; $display("[TB] FAIL rstb_cdb got=%h exp=0", cdb_out); end
    checks++; if (hold_count !== 3'd0) begin failures++; $display("[TB] FAIL rstb_count got=%0d exp=0", hold_count); end
    checks++; if (fu_ready !== 5'b11111) begin failures++; $display("[TB] FAIL rstb_ready got=%b exp=11111", fu_ready); end
    checks++; if (dut.rr_ptr !== 3'd0) begin failures++; $display("[TB] FAIL rstb_ptr got=%0d exp=0", dut.rr_ptr); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_squash_grant();
    test_squash_incoming();
    test_clear();
    test_back_to_back();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
